// File: rtl/ucie_ctl_sb_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing the sideband TX path between NREQ message sources.
// Issues one message at a time, tracks the busy handshake and acks the owner (with error on timeout).
module ucie_ctl_sb_tx_arbiter #(
    parameter int NREQ    = 3,
    parameter int BUSY_TO = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NREQ-1:0]   i_req,
    input  logic [NREQ*5-1:0] i_req_decode,
    input  logic [NREQ*32-1:0] i_req_data,
    output logic [NREQ-1:0]   o_ack,
    output logic              o_err,
    output logic [NREQ-1:0]   o_grant,
    output logic              o_valid_lp_sb,
    output logic [4:0]        o_rdi_lp_sb_decode,
    output logic [31:0]       o_rdi_lp_adv_cap_value,
    input  logic              i_pl_sb_busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DONE} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   gidx_q, gidx_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            to_q, to_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            err_q, err_d;
    logic            valid_q, valid_d;
    logic [4:0]      dec_q, dec_d;
    logic [31:0]     data_q, data_d;

    logic [4:0]      dec_arr  [NREQ];
    logic [31:0]     data_arr [NREQ];
    logic            sel_found;
    logic [PW-1:0]   sel_idx;
    logic [PW-1:0]   idx_w;
    int              idx;

    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            dec_arr[k]  = i_req_decode[5*k +: 5];
            data_arr[k] = i_req_data[32*k +: 32];
        end
    end

    // First set request scanning upward from the pointer, wrapping modulo NREQ.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        idx       = 0;
        idx_w     = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            idx_w = idx[PW-1:0];
            if (!sel_found && i_req[idx_w]) begin
                sel_found = 1'b1;
                sel_idx   = idx_w;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        cnt_d   = cnt_q;
        to_d    = to_q;
        grant_d = grant_q;
        dec_d   = dec_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ack_d   = '0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!i_pl_sb_busy && sel_found) begin
                    gidx_d  = sel_idx;
                    grant_d = NREQ'(1) << sel_idx;
                    dec_d   = dec_arr[sel_idx];
                    data_d  = data_arr[sel_idx];
                    valid_d = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (i_pl_sb_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == 8'(BUSY_TO - 1)) begin
                    to_d    = 1'b1;
                    ack_d   = grant_q;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WAIT_DONE: begin
                if (!i_pl_sb_busy) begin
                    ack_d   = grant_q;
                    err_d   = to_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                ptr_d   = (gidx_q == PW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
                grant_d = '0;
                to_d    = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gidx_q  <= '0;
            cnt_q   <= '0;
            to_q    <= 1'b0;
            grant_q <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            dec_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            dec_q   <= dec_d;
            data_q  <= data_d;
        end
    end

    assign o_ack                  = ack_q;
    assign o_err                  = err_q;
    assign o_grant                = grant_q;
    assign o_valid_lp_sb          = valid_q;
    assign o_rdi_lp_sb_decode     = dec_q;
    assign o_rdi_lp_adv_cap_value = data_q;

endmodule

// File: doc/ucie_ctl_sb_tx_arbiter.md
Name: ucie_ctl_sb_tx_arbiter

Overview:
Round-robin arbiter and sequencer in front of the sideband TX path (FSM, packet builder, packet sender). It shares that single TX datapath between NREQ message sources, such as the LSM state-request source, the parameter-exchange source and the error-message source. It issues one message at a time on the TX-top interface (valid / decode / adv-cap value) and tracks the busy handshake to completion. It returns a per-requester acknowledge, plus an error pulse if the TX path never accepts a message.

Parameters:
NREQ, 3, number of requesters (2..8)
BUSY_TO, 8, cycles to wait for busy assertion after issue before declaring failure (1..255)

Ports:
i_clk  input  1  clock
i_rst  input  1  asynchronous reset, active-high
i_req  input  NREQ  per-requester request level; held until matching o_ack
i_req_decode  input  NREQ*5  packed sb decodes; requester k at [5k+4:5k]
i_req_data  input  NREQ*32  packed adv-cap values; requester k at [32k+31:32k]
o_ack  output  NREQ  one-cycle completion pulse to the granted requester
o_err  output  1  one-cycle pulse coincident with o_ack when the issue timed out
o_grant  output  NREQ  one-hot current owner; 0 when idle
o_valid_lp_sb  output  1  to TX top: message valid strobe
o_rdi_lp_sb_decode  output  5  to TX top: decode of granted message
o_rdi_lp_adv_cap_value  output  32  to TX top: data of granted message
i_pl_sb_busy  input  1  from TX top: sideband TX busy

Behaviour:
- Reset values: all outputs 0, state IDLE, priority pointer 0, timeout counter 0.
- All outputs are registered. The FSM has states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DONE.
- IDLE: if i_pl_sb_busy=1, stay in IDLE and grant nothing. Otherwise, if any i_req bit is set, select the first set bit scanning from pointer p upward, wrapping modulo NREQ. On that edge, latch the selected decode and data into the output registers, set o_grant one-hot, and go to ISSUE.
- ISSUE: o_valid_lp_sb=1 for exactly one cycle. Clear the counter and go to WAIT_BUSY.
- WAIT_BUSY: if i_pl_sb_busy=1, go to WAIT_DONE. Otherwise increment the counter. When the counter reaches BUSY_TO-1 with busy still 0, set the timeout flag and go to DONE.
- WAIT_DONE: stay while i_pl_sb_busy=1. When busy=0, go to DONE.
- DONE: for one cycle, o_ack[g]=1 and o_err=timeout flag. Set p=(g+1) mod NREQ, clear o_grant and the flag, and go to IDLE.
- o_rdi_lp_sb_decode and o_rdi_lp_adv_cap_value stay constant from ISSUE through DONE. They hold their last value in IDLE and are never re-sampled mid-transaction.
- Requester turnaround: a requester re-arbitrates no earlier than the cycle after its o_ack. Its i_req in the o_ack cycle is ignored because DONE does not arbitrate, so back-to-back grants to the same source are separated by at least one IDLE cycle.
- If i_req[g] drops mid-transaction, the transaction still completes and o_ack[g] still pulses.
- If requests arrive simultaneously, the round-robin order is strict. No requester is granted twice while another requester is continuously waiting.
- Minimum transaction is 5 cycles: IDLE→ISSUE→WAIT_BUSY→WAIT_DONE→DONE with a one-cycle busy.
- Asserting i_rst in any state returns everything to its reset values immediately. No ack is generated for the aborted transaction.
- i_req bits whose index is ≥ NREQ do not exist. Do not infer latches for unused mux slots.

Test Plan:
- Single request: i_req=3'b010, decode=5'h07, data=32'hA5A5_0001, TX top busy for 4 cycles starting 2 cycles after valid. Required: one valid pulse with decode 07/data A5A5_0001, o_grant=3'b010 throughout, o_ack=3'b010 exactly once, o_err=0, p=2 afterwards.
- All three requesting from reset and held: grants in order 0,1,2,0 with 3 acks each separated by ≥1 IDLE cycle. Decode/data per grant match that requester's slice.
- Busy never asserts, BUSY_TO=8: o_ack and o_err pulse together, exactly 8 cycles after the WAIT_BUSY entry edge. The next request is then served normally.
- i_pl_sb_busy already high while i_req=3'b001: no grant, no valid until busy falls. Then the grant is issued on the next edge.
- Requester drops i_req during WAIT_DONE: o_ack still pulses for it and no second valid is issued.
- i_rst pulsed during WAIT_DONE: all outputs 0 asynchronously, no ack, and arbitration restarts from pointer 0 after release.
